// File: rtl/frame_render_controller_pkg.sv
// Shared definitions for the frame render controller.
//   MAX_OBJECTS_DEFAULT : default per-frame object ceiling
//   frame_ctrl_state_t  : controller state encoding
//   state_is_busy()     : true for every state except IDLE and AWAIT_MCU
package frame_render_controller_pkg;

  localparam int MAX_OBJECTS_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_AWAIT_MCU    = 3'd1,
    ST_CLEAR        = 3'd2,
    ST_RENDER_START = 3'd3,
    ST_RENDER_WAIT  = 3'd4,
    ST_SWAP_WAIT    = 3'd5,
    ST_DONE         = 3'd6
  } frame_ctrl_state_t;

  function automatic logic state_is_busy(input frame_ctrl_state_t s);
    return !(s == ST_IDLE || s == ST_AWAIT_MCU);
  endfunction

endpackage

// File: rtl/frame_render_controller_frame_cycle_counter.sv
// Frame duration counter.
//   clk, rst   : clock, async active-high reset
//   i_start    : clear the running count (frame begins)
//   i_run      : count this cycle (saturating at all-ones)
//   i_capture  : copy the running count to o_cycles
//   o_cycles   : last captured frame duration in clk cycles
module frame_cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_run,
  input  logic        i_capture,
  output logic [31:0] o_cycles
);

  logic [31:0] cnt_q;
  logic [31:0] cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (i_start) begin
      cnt_q <= '0;
    end else if (i_run && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q <= '0;
    end else if (i_capture) begin
      cycles_q <= cnt_q;
    end
  end

  assign o_cycles = cycles_q;

endmodule

// File: rtl/frame_render_controller.sv
// Frame render sequencing controller: accepts an object count from the MCU,
// optionally clears the framebuffer, issues one render-pipeline start per
// object, waits for the display frame pulse, swaps buffers, signals done.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   i_num_objects[_dv]          per-frame object count from the MCU
//   o_mcu_ready                 high while a new count can be accepted
//   o_clear_start/i_clear_done  framebuffer clear handshake
//   o_rp_start/i_rp_ready       render pipeline start / idle
//   i_rp_finished               one object completed
//   i_frame                     display frame pulse (synchronous)
//   o_swap                      buffer swap pulse
//   i_abort                     abandon the current frame
//   o_busy, o_frame_done        status
//   o_objects_rendered          objects completed in this frame
//   o_frame_cycles              (FRAME_CTRL_STATS_EN only) frame duration
//
// Build option: define FRAME_CTRL_STATS_EN to add o_frame_cycles.
//
// state        | meaning
// IDLE         | waiting for the render pipeline to be idle
// AWAIT_MCU    | waiting for an object count
// CLEAR        | framebuffer clear in progress
// RENDER_START | issue the next object start when the pipeline is ready
// RENDER_WAIT  | waiting for the current object to finish
// SWAP_WAIT    | waiting for the display frame pulse
// DONE         | frame complete
module frame_render_controller
  import frame_render_controller_pkg::*;
#(
  parameter int MAX_OBJECTS = MAX_OBJECTS_DEFAULT,
  parameter int OBJ_W       = $clog2(MAX_OBJECTS + 1),
  parameter int WAIT_VSYNC  = 1,
  parameter int CLEAR_FB    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OBJ_W-1:0] i_num_objects,
  input  logic             i_num_objects_dv,
  output logic             o_mcu_ready,
  output logic             o_clear_start,
  input  logic             i_clear_done,
  output logic             o_rp_start,
  input  logic             i_rp_ready,
  input  logic             i_rp_finished,
  input  logic             i_frame,
  output logic             o_swap,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [OBJ_W-1:0] o_objects_rendered
`ifdef FRAME_CTRL_STATS_EN
  ,
  output logic [31:0]      o_frame_cycles
`endif
);

  localparam logic [OBJ_W-1:0] MAX_CNT = OBJ_W'(MAX_OBJECTS);

  frame_ctrl_state_t state_q, state_d;
  logic [OBJ_W-1:0]  target_q, target_d;
  logic [OBJ_W-1:0]  rendered_q, rendered_d;
  logic [OBJ_W-1:0]  rendered_inc;
  logic              clear_start_q, clear_start_d;
  logic              rp_start_q, rp_start_d;
  logic              swap_q, swap_d;
  logic              frame_done_q, frame_done_d;
  logic              mcu_ready_q;
  logic              busy_q;

  assign rendered_inc = rendered_q + OBJ_W'(1);

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    rendered_d    = rendered_q;
    clear_start_d = 1'b0;
    rp_start_d    = 1'b0;
    swap_d        = 1'b0;
    frame_done_d  = 1'b0;
    // Abort overrides every other event, including a coincident finish,
    // so the rendered count holds and no further pulses are produced.
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_rp_ready) state_d = ST_AWAIT_MCU;
        end
        ST_AWAIT_MCU: begin
          if (i_num_objects_dv) begin
            target_d      = (i_num_objects > MAX_CNT) ? MAX_CNT : i_num_objects;
            rendered_d    = '0;
            clear_start_d = (CLEAR_FB != 0);
            state_d       = (CLEAR_FB != 0) ? ST_CLEAR : ST_RENDER_START;
          end
        end
        ST_CLEAR: begin
          if (i_clear_done) state_d = ST_RENDER_START;
        end
        ST_RENDER_START: begin
          if (target_q == '0) begin
            state_d = ST_SWAP_WAIT;
          end else if (i_rp_ready) begin
            rp_start_d = 1'b1;
            state_d    = ST_RENDER_WAIT;
          end
        end
        ST_RENDER_WAIT: begin
          if (i_rp_finished) begin
            rendered_d = rendered_inc;
            state_d    = (rendered_inc == target_q) ? ST_SWAP_WAIT : ST_RENDER_START;
          end
        end
        ST_SWAP_WAIT: begin
          // Only frame pulses seen while in this state count.
          if (i_frame || (WAIT_VSYNC == 0)) begin
            swap_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      rendered_q    <= '0;
      clear_start_q <= 1'b0;
      rp_start_q    <= 1'b0;
      swap_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      mcu_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      rendered_q    <= rendered_d;
      clear_start_q <= clear_start_d;
      rp_start_q    <= rp_start_d;
      swap_q        <= swap_d;
      frame_done_q  <= frame_done_d;
      // Registered from the next state so these track state_q exactly.
      mcu_ready_q   <= (state_d == ST_AWAIT_MCU);
      busy_q        <= state_is_busy(state_d);
    end
  end

  assign o_mcu_ready        = mcu_ready_q;
  assign o_clear_start      = clear_start_q;
  assign o_rp_start         = rp_start_q;
  assign o_swap             = swap_q;
  assign o_busy             = busy_q;
  assign o_frame_done       = frame_done_q;
  assign o_objects_rendered = rendered_q;

`ifdef FRAME_CTRL_STATS_EN
  logic stat_start;
  logic stat_run;
  logic stat_capture;

  // Duration covers every cycle after AWAIT_MCU up to (not including) DONE.
  assign stat_start   = (state_q == ST_AWAIT_MCU) && (state_d != ST_AWAIT_MCU);
  assign stat_run     = state_is_busy(state_q) && (state_q != ST_DONE);
  assign stat_capture = (state_q == ST_DONE) && !i_abort;

  frame_cycle_counter u_frame_cycle_counter (
    .clk       (clk),
    .rst       (rst),
    .i_start   (stat_start),
    .i_run     (stat_run),
    .i_capture (stat_capture),
    .o_cycles  (o_frame_cycles)
  );
`else
  // Statistics disabled: no duration counter is built.
`endif

endmodule

// File: tb/tb_frame_render_controller.sv
// Directed bench: three controller instances with different build parameters
// (0: clear + vsync, 1: no clear + vsync, 2: no clear + no vsync) share the
// clock and reset; each has its own stimulus and response signals.
module tb_frame_render_controller;
  import frame_render_controller_pkg::*;

  localparam int OW = $clog2(MAX_OBJECTS_DEFAULT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    dv, clr_done, rp_ready, rp_fin, frame, abort;
  logic [2:0]    mcu_ready, clear_start, rp_start, swap, busy, frame_done;
  logic [OW-1:0] num [3];
  logic [OW-1:0] rnd [3];
`ifdef FRAME_CTRL_STATS_EN
  logic [31:0]   fcyc [3];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    frame_render_controller #(
      .CLEAR_FB   ((g == 0) ? 1 : 0),
      .WAIT_VSYNC ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk                (clk),
      .rst                (rst),
      .i_num_objects      (num[g]),
      .i_num_objects_dv   (dv[g]),
      .o_mcu_ready        (mcu_ready[g]),
      .o_clear_start      (clear_start[g]),
      .i_clear_done       (clr_done[g]),
      .o_rp_start         (rp_start[g]),
      .i_rp_ready         (rp_ready[g]),
      .i_rp_finished      (rp_fin[g]),
      .i_frame            (frame[g]),
      .o_swap             (swap[g]),
      .i_abort            (abort[g]),
      .o_busy             (busy[g]),
      .o_frame_done       (frame_done[g]),
      .o_objects_rendered (rnd[g])
`ifdef FRAME_CTRL_STATS_EN
      , .o_frame_cycles   (fcyc[g])
`endif
    );
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Runs one frame on instance k with a reactive pipeline model.
  // fin_dly: cycles from o_rp_start to i_rp_finished
  // abort_at: finish number that coincides with i_abort (0 = none)
  // hold: cycles i_rp_ready is held low after the count is given (0 = none)
  task automatic run_frame(input string tag, input int k, input int n,
                           input int fin_dly, input int abort_at, input int hold);
    int  n_exp, dv_cyc, fin_at, clr_at, hold_end, sw_cyc, fr_cyc, exp_swap;
    int  n_rp, n_clr, n_swap, n_done, n_fin, swap_cyc, done_cyc, first_rp;
    int  abort_cyc, exp_rnd, rnd_err, t;
    bit  vsync, stop;
    n_exp = (n > MAX_OBJECTS_DEFAULT) ? MAX_OBJECTS_DEFAULT : n;
    vsync = (k != 2);
    fin_at = -1; clr_at = -1; hold_end = -1; fr_cyc = -1;
    n_rp = 0; n_clr = 0; n_swap = 0; n_done = 0; n_fin = 0;
    swap_cyc = -1; done_cyc = -1; first_rp = -1; abort_cyc = -1;
    exp_rnd = 0; rnd_err = 0;

    t = 0;
    while (!mcu_ready[k] && t < 50) begin
      cyc();
      t++;
    end
    check_eq({tag, " mcu_ready"}, mcu_ready[k], 1);

    num[k] = OW'(n);
    dv[k]  = 1'b1;
    dv_cyc = cyc_n;
    if (hold > 0) begin
      rp_ready[k] = 1'b0;
      hold_end    = dv_cyc + hold;
    end
    // Zero-count frames (no clear) reach SWAP_WAIT two cycles after the count.
    sw_cyc = (n_exp == 0) ? dv_cyc + 2 : -1;

    stop = 1'b0;
    t = 0;
    while (!stop && t < 6000) begin
      cyc();
      t++;
      dv[k] = 1'b0; rp_fin[k] = 1'b0; clr_done[k] = 1'b0;
      frame[k] = 1'b0; abort[k] = 1'b0;

      if (rnd[k] != OW'(exp_rnd)) rnd_err++;
      if (cyc_n == dv_cyc + 1) begin
        check_eq({tag, " busy in frame"}, busy[k], 1);
        check_eq({tag, " mcu_ready in frame"}, mcu_ready[k], 0);
      end
      if (rp_start[k]) begin
        n_rp++;
        if (first_rp < 0) first_rp = cyc_n;
        fin_at      = cyc_n + fin_dly;
        rp_ready[k] = 1'b0;
      end
      if (clear_start[k]) begin
        n_clr++;
        clr_at = cyc_n + 2;
      end
      if (swap[k]) begin
        n_swap++;
        if (swap_cyc < 0) swap_cyc = cyc_n;
      end
      if (frame_done[k]) begin
        n_done++;
        done_cyc = cyc_n;
        check_eq({tag, " busy after done"}, busy[k], 0);
        if (abort_at == 0) stop = 1'b1;
      end

      if (cyc_n == clr_at) clr_done[k] = 1'b1;
      // A stray finish while waiting in RENDER_START must be ignored.
      if (hold > 0 && cyc_n == dv_cyc + 3) rp_fin[k] = 1'b1;
      if (hold > 0 && cyc_n == hold_end) rp_ready[k] = 1'b1;
      if (cyc_n == fin_at) begin
        rp_fin[k]   = 1'b1;
        rp_ready[k] = 1'b1;
        n_fin++;
        if (n_fin == abort_at) begin
          abort[k]  = 1'b1;
          abort_cyc = cyc_n;
        end else begin
          exp_rnd = n_fin;
          if (n_fin == n_exp) sw_cyc = cyc_n + 1;
        end
      end
      // Frame pulses arrive every 7 cycles, including during rendering.
      if (cyc_n % 7 == 3) begin
        frame[k] = 1'b1;
        if (sw_cyc >= 0 && cyc_n >= sw_cyc && fr_cyc < 0) fr_cyc = cyc_n;
      end
      if (abort_cyc >= 0 && cyc_n == abort_cyc + 1)
        check_eq({tag, " busy after abort"}, busy[k], 0);
      if (abort_cyc >= 0 && cyc_n >= abort_cyc + 30) stop = 1'b1;
    end
    check_eq({tag, " finished in budget"}, stop, 1);

    check_eq({tag, " clear_start count"}, n_clr, (k == 0) ? 1 : 0);
    check_eq({tag, " rendered trace"}, rnd_err, 0);
    if (abort_at == 0) begin
      exp_swap = vsync ? fr_cyc + 1 : sw_cyc + 1;
      check_eq({tag, " rp_start count"}, n_rp, n_exp);
      check_eq({tag, " rendered final"}, rnd[k], n_exp);
      check_eq({tag, " swap count"}, n_swap, 1);
      check_eq({tag, " swap cycle"}, swap_cyc, exp_swap);
      check_eq({tag, " frame_done count"}, n_done, 1);
      check_eq({tag, " frame_done cycle"}, done_cyc, exp_swap + 1);
      if (hold > 0) check_eq({tag, " first rp_start"}, first_rp, hold_end + 1);
    end else begin
      check_eq({tag, " rp_start count"}, n_rp, abort_at);
      check_eq({tag, " rendered held"}, rnd[k], abort_at - 1);
      check_eq({tag, " swap count"}, n_swap, 0);
      check_eq({tag, " frame_done count"}, n_done, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    dv = '0; clr_done = '0; rp_fin = '0; frame = '0; abort = '0;
    rp_ready = 3'b111;
    for (int i = 0; i < 3; i++) num[i] = '0;

    repeat (3) cyc();
    check_eq("rst mcu_ready", mcu_ready[0], 0);
    check_eq("rst busy", busy[0], 0);
    check_eq("rst clear_start", clear_start[0], 0);
    check_eq("rst rp_start", rp_start[0], 0);
    check_eq("rst swap", swap[0], 0);
    check_eq("rst frame_done", frame_done[0], 0);
    check_eq("rst rendered", rnd[0], 0);
`ifdef FRAME_CTRL_STATS_EN
    check_eq("rst frame_cycles", fcyc[2], 0);
`endif
    rst = 1'b0;

    run_frame("count3", 0, 3, 3, 0, 0);
    run_frame("count0", 1, 0, 2, 0, 0);
    run_frame("count2000", 0, 2000, 1, 0, 0);
    run_frame("ready_hold", 1, 1, 2, 0, 10);
    run_frame("abort", 0, 4, 3, 2, 0);
    run_frame("after_abort", 0, 2, 2, 0, 0);
    run_frame("no_vsync", 2, 1, 5, 0, 0);
`ifdef FRAME_CTRL_STATS_EN
    // RENDER_START 1 + RENDER_WAIT (5+1) + SWAP_WAIT 1 cycles.
    check_eq("frame_cycles", fcyc[2], 8);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/frame_render_controller.md
FRAME_RENDER_CONTROLLER -- requirements
Module: frame_render_controller

Interface
REQ-001 SHALL have parameter MAX_OBJECTS, default 1024, the maximum number of objects rendered per frame.
REQ-002 SHALL have parameter OBJ_W, default $clog2(MAX_OBJECTS+1), the width of object counts.
REQ-003 SHALL have parameter WAIT_VSYNC, default 1; when 1, the controller waits for a display frame pulse before the buffer swap.
REQ-004 SHALL have parameter CLEAR_FB, default 1; when 1, the controller runs a framebuffer clear before rendering.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  the one clock for the block.
- rst  in  1  asynchronous, active-high reset.
- i_num_objects  in  OBJ_W  object count for the frame, from the MCU.
- i_num_objects_dv  in  1  i_num_objects valid.
- o_mcu_ready  out  1  controller can accept a new frame count.
- o_clear_start  out  1  one-cycle framebuffer-clear request.
- i_clear_done  in  1  clear complete.
- o_rp_start  out  1  one-cycle render pipeline start.
- i_rp_ready  in  1  render pipeline idle.
- i_rp_finished  in  1  one-cycle object-complete pulse.
- i_frame  in  1  display frame pulse, already synchronous to clk.
- o_swap  out  1  one-cycle buffer-swap pulse.
- i_abort  in  1  abandon the current frame.
- o_busy  out  1  high in every state except IDLE and AWAIT_MCU.
- o_frame_done  out  1  one-cycle end-of-frame pulse.
- o_objects_rendered  out  OBJ_W  running object count for the frame.

Function
REQ-006 States SHALL be IDLE, AWAIT_MCU, CLEAR, RENDER_START, RENDER_WAIT, SWAP_WAIT and DONE.
REQ-007 IDLE SHALL move to AWAIT_MCU when i_rp_ready=1.
REQ-008 AWAIT_MCU:
- o_mcu_ready SHALL be 1 only in this state.
- On i_num_objects_dv, SHALL latch min(i_num_objects, MAX_OBJECTS) and clear o_objects_rendered.
- Next state SHALL be CLEAR if CLEAR_FB=1, otherwise RENDER_START.
REQ-009 On entering CLEAR, o_clear_start SHALL pulse for exactly one cycle; the controller SHALL stay in CLEAR until i_clear_done, then go to RENDER_START.
REQ-010 Zero-object frame: if the latched count is 0, RENDER_START SHALL go directly to SWAP_WAIT without asserting o_rp_start.
REQ-011 RENDER_START SHALL assert o_rp_start for one cycle only when i_rp_ready=1, then go to RENDER_WAIT; if i_rp_ready=0 it SHALL hold.
REQ-012 RENDER_WAIT object completion (i_rp_finished):
- SHALL increment o_objects_rendered.
- If the new value equals the latched count, SHALL go to SWAP_WAIT; otherwise SHALL go to RENDER_START.
- Any i_rp_finished seen outside RENDER_WAIT SHALL be ignored.
REQ-013 SWAP_WAIT SHALL pulse o_swap and go to DONE on the first i_frame (WAIT_VSYNC=1), or on the first cycle in the state (WAIT_VSYNC=0).
REQ-014 An i_frame pulse arriving before SWAP_WAIT SHALL NOT satisfy the wait.
REQ-015 DONE SHALL pulse o_frame_done for one cycle, then go to IDLE.
REQ-016 i_abort SHALL take the controller to IDLE on the next edge from any state.
REQ-017 Abort behaviour:
- No o_swap or o_frame_done SHALL be issued for an aborted frame.
- o_objects_rendered SHALL hold its value.
- i_abort SHALL take priority over every simultaneous event.
REQ-018 All outputs SHALL be registered; the count SHALL never exceed MAX_OBJECTS.

Reset
REQ-019 While rst=1, the state SHALL be IDLE.
REQ-020 While rst=1, every output and o_objects_rendered SHALL be 0.
REQ-021 Reset asserted mid-frame SHALL abandon the frame with no further pulses.

Configuration
REQ-022 Macro FRAME_CTRL_STATS_EN SHALL compile in the statistics feature.
- With the macro defined: a 32-bit output o_frame_cycles SHALL count clk cycles from leaving AWAIT_MCU to DONE (saturating), be captured at DONE, and be reset to 0.
- Without the macro: the port and its counter SHALL be absent, and all other behaviour is identical.

Structure
REQ-023 A shared package SHALL hold the state enum typedef frame_ctrl_state_t and the default MAX_OBJECTS constant.
REQ-024 There SHALL be one sub-module, frame_cycle_counter, instantiated only under FRAME_CTRL_STATS_EN.

Verification
REQ-025 Count 3, CLEAR_FB=1, WAIT_VSYNC=1: SHALL see 1 o_clear_start, 3 o_rp_start, o_objects_rendered 0→1→2→3, o_swap on the first i_frame after the third finish, then o_frame_done.
REQ-026 Count 0, CLEAR_FB=0: SHALL see no o_rp_start, o_swap on the next i_frame, then o_frame_done; o_objects_rendered=0.
REQ-027 Count 2000 with MAX_OBJECTS=1024: SHALL see exactly 1024 o_rp_start pulses before o_swap.
REQ-028 Hold i_rp_ready=0 for 10 cycles in RENDER_START: SHALL see no o_rp_start until i_rp_ready rises, then exactly one pulse.
REQ-029 i_abort coincident with i_rp_finished at object 2 of 4: SHALL go to IDLE, o_objects_rendered=1, and no o_swap or o_frame_done.
REQ-030 With FRAME_CTRL_STATS_EN, WAIT_VSYNC=0, CLEAR_FB=0, count 1, and i_rp_finished 5 cycles after o_rp_start: o_frame_cycles SHALL equal the cycle count from leaving AWAIT_MCU to DONE computed by the bench's reference model.
